ps2_scan_decode: RTL and testbench
==================================

// Module: ps2_scan_decode
// PURPOSE
//  Consumes raw PS/2 set-2 scancode bytes from the keyboard receiver.
//  Resolves the F0 (break), E0 (extended) and E1 (Pause) prefixes into single key events.
//  Tracks live modifier state and buffers events in a small FIFO read with a valid/ready handshake.
//  Sits between the PS/2 receiver and the MMIO keyboard register front-end.
// PARAMETERS
//  DEPTH    4      event FIFO entries; must be a power of 2, >=2
//  TIMEOUT  65535  idle cycles a prefix state may wait for its next byte before abort
// PORTS
//  clock      in   1   single clock; all logic on posedge
//  reset      in   1   synchronous, active-low reset
//  scanValid  in   1   one-cycle strobe: scanByte holds a received byte
//  scanByte   in   8   raw scancode byte
//  keyValid   out  1   FIFO head valid
//  keyReady   in   1   consumer pops the head when keyValid && keyReady
//  keyCode    out  9   {extended, code}; Pause = 9'h1E1
//  keyBreak   out  1   1 = key release, 0 = key press
//  keyMods    out  8   modifier snapshot stored with the event
//  modState   out  8   live modifier state
//  kbStat     out  8   sticky status: [0]AA BAT-ok [1]FA ack [2]FE resend [3]EE echo
//                      [4]00/FF error [5]FIFO overflow [6]prefix timeout [7]0
//  statClr    in   1   clears all kbStat bits
// BEHAVIOUR
//  Reset (reset==0 at posedge): FSM=IDLE; FIFO empty; keyValid=0; keyCode=0; keyBreak=0;
//   keyMods=0; modState=0; kbStat=0; timeout counter=0.
//  FSM states and transitions, applied only on scanValid:
//   IDLE:   F0->BRK; E0->EXT; E1->PAUSE (cnt=0); AA/FA/FE/EE/00/FF set the kbStat bit, no event;
//           any other byte emits a make event {0,b}.
//   BRK:    emit break {0,b}, ->IDLE.
//   EXT:    F0->EXTBRK; 12/59 (fake shift) are discarded ->IDLE; else emit make {1,b} ->IDLE.
//   EXTBRK: 12/59 are discarded; else emit break {1,b}; ->IDLE.
//   PAUSE:  swallow 7 further bytes; on the 7th emit one make 9'h1E1 ->IDLE.
//           Pause produces no break event and no modifier change.
//  Timeout: any non-IDLE state with no scanValid for TIMEOUT consecutive cycles ->IDLE, kbStat[6]=1.
//   The pending prefix is dropped. The counter resets on every scanValid and on entry to IDLE.
//  Modifier map (bit:code): 0:12 LShift, 1:59 RShift, 2:14 LCtrl, 3:E0 14 RCtrl,
//   4:11 LAlt, 5:E0 11 RAlt, 6:E0 1F LGui, 7:E0 27 RGui.
//   A make sets the bit and a break clears it, in the same cycle as the emit.
//   keyMods carries the post-update value: a make includes its own bit, a break excludes it.
//  Latency: an event emitted on the posedge that samples scanValid is visible at the FIFO head
//   after that edge (keyValid=1 the next cycle when the FIFO was empty).
//  FIFO: entry = {keyCode, keyBreak, keyMods} = 18b, first-in first-out.
//   Pop when keyValid&&keyReady; the head is registered.
//   Push while full with no pop: new event dropped, kbStat[5]=1, contents unchanged.
//   Push+pop in the same cycle while full: both happen, no overflow.
//   Push+pop while holding 1 entry: new entry becomes head, keyValid stays 1.
//  statClr: clears kbStat. A status set in the same cycle wins (bit reads 1).
//  Bytes arriving while reset is asserted are ignored. Reset mid-sequence discards the prefix.
// STRUCTURE
//  Shared package: prefix byte constants (F0,E0,E1,AA,FA,FE,EE), modifier code table,
//   FSM state encoding, kbStat bit indices, PAUSE_CODE=9'h1E1, event entry width.
//  Sub-module: ps2_evt_fifo (DEPTH x 18b, push/pop/full/empty/count). The decode FSM stays in this module.
// TESTING
//  1C -> one event keyCode=9'h01C, keyBreak=0, keyMods=0; keyValid next cycle.
//  E0 F0 75 -> one event keyCode=9'h175, keyBreak=1; FSM returns to IDLE.
//  12, 1C, F0 12 -> events 012/make/mods=01, 01C/make/mods=01, 012/break/mods=00; modState ends 00.
//  E1 14 77 E1 F0 14 F0 77 -> exactly one event 9'h1E1 make; modState stays 00.
//   E0 12 and E0 F0 12 -> no events.
//  keyReady=0, send five makes 1C..20 (DEPTH=4) -> 4 entries held, kbStat[5]=1;
//   draining yields 1C,1D,1E,1F in order.
//  E0, wait TIMEOUT cycles, then 1C -> kbStat[6]=1, event 9'h01C.
//   AA -> no event, kbStat[0]=1; statClr -> kbStat=0.

Source files
------------

// File: rtl/ps2_scan_decode_pkg.sv
// Shared definitions for the PS/2 set-2 scancode decoder: prefix bytes, FSM encoding,
// status bit positions, modifier table and event entry layout.
package ps2_scan_decode_pkg;

  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_EE = 8'hEE;

  localparam logic [8:0] PAUSE_CODE = 9'h1E1;
  localparam int         EVT_W      = 18;

  localparam int STAT_BAT    = 0;
  localparam int STAT_ACK    = 1;
  localparam int STAT_RESEND = 2;
  localparam int STAT_ECHO   = 3;
  localparam int STAT_ERR    = 4;
  localparam int STAT_OVF    = 5;
  localparam int STAT_TMO    = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BRK    = 3'd1,
    ST_EXT    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } scanState_t;

  // Index i is the modState bit owned by the {extended, code} value in entry i.
  localparam logic [8:0] MOD_CODES [8] = '{
    9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111, 9'h11F, 9'h127
  };

  function automatic logic [7:0] modMask(input logic [8:0] code);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (code == MOD_CODES[i]) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_scan_decode_if.sv
// Bundle between the decoder, the PS/2 byte receiver and the keyboard register front-end.
interface ps2_scan_decode_if;
  // Handshake: scanValid is a one-cycle strobe with no back-pressure; an event leaves
  // the FIFO on every clock where keyValid && keyReady, and keyValid never drops
  // without that pop.
  logic       scanValid;
  logic [7:0] scanByte;
  logic       keyValid;
  logic       keyReady;
  logic [8:0] keyCode;
  logic       keyBreak;
  logic [7:0] keyMods;
  logic [7:0] modState;
  logic [7:0] kbStat;
  logic       statClr;

  modport master (
    output scanValid, scanByte, keyReady, statClr,
    input  keyValid, keyCode, keyBreak, keyMods, modState, kbStat
  );

  modport slave (
    input  scanValid, scanByte, keyReady, statClr,
    output keyValid, keyCode, keyBreak, keyMods, modState, kbStat
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Power-of-two event FIFO with a registered head; a push is accepted when full only
// if a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_scan_decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [EVT_W-1:0]       pushData,
  input  logic                   pop,
  output logic [EVT_W-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

endmodule

// File: rtl/ps2_scan_decode.sv
// PS/2 set-2 decoder: folds F0/E0/E1 prefixes into single key events, tracks modifiers
// and queues {keyCode, keyBreak, keyMods} entries for the register front-end.
module ps2_scan_decode
  import ps2_scan_decode_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  ps2_scan_decode_if.slave       bus,
  output scanState_t             dbgState,
  output logic [$clog2(DEPTH):0] dbgCount
);
  localparam int TW = $clog2(TIMEOUT + 1);

  scanState_t       state;
  scanState_t       nextState;
  logic [TW-1:0]    idleCnt;
  logic [2:0]       pauseCnt;
  logic             timedOut;
  logic             fakeShift;
  logic             emit;
  logic             evtBreak;
  logic [8:0]       evtCode;
  logic [7:0]       evtMods;
  logic [7:0]       statSet;
  logic [7:0]       modQ;
  logic [7:0]       statQ;
  logic             pop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [EVT_W-1:0] head;

  assign fakeShift = (bus.scanByte == 8'h12) || (bus.scanByte == 8'h59);
  assign timedOut  = (state != ST_IDLE) && !bus.scanValid && (idleCnt == TW'(TIMEOUT - 1));
  assign pop       = bus.keyValid && bus.keyReady;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (timedOut) begin
      nextState = ST_IDLE;
    end else if (bus.scanValid) begin
      case (state)
        ST_IDLE: begin
          if      (bus.scanByte == BYTE_F0) nextState = ST_BRK;
          else if (bus.scanByte == BYTE_E0) nextState = ST_EXT;
          else if (bus.scanByte == BYTE_E1) nextState = ST_PAUSE;
        end
        ST_EXT:   nextState = (bus.scanByte == BYTE_F0) ? ST_EXTBRK : ST_IDLE;
        ST_PAUSE: nextState = (pauseCnt == 3'd6) ? ST_IDLE : ST_PAUSE;
        default:  nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    evtBreak = 1'b0;
    evtCode  = '0;
    statSet  = '0;
    if (timedOut) begin
      statSet[STAT_TMO] = 1'b1;
    end else if (bus.scanValid) begin
      case (state)
        ST_IDLE: begin
          case (bus.scanByte)
            BYTE_F0, BYTE_E0, BYTE_E1: ;
            BYTE_AA:     statSet[STAT_BAT]    = 1'b1;
            BYTE_FA:     statSet[STAT_ACK]    = 1'b1;
            BYTE_FE:     statSet[STAT_RESEND] = 1'b1;
            BYTE_EE:     statSet[STAT_ECHO]   = 1'b1;
            8'h00, 8'hFF: statSet[STAT_ERR]   = 1'b1;
            default: begin
              emit    = 1'b1;
              evtCode = {1'b0, bus.scanByte};
            end
          endcase
        end
        ST_BRK: begin
          emit     = 1'b1;
          evtBreak = 1'b1;
          evtCode  = {1'b0, bus.scanByte};
        end
        ST_EXT: begin
          emit    = (bus.scanByte != BYTE_F0) && !fakeShift;
          evtCode = {1'b1, bus.scanByte};
        end
        ST_EXTBRK: begin
          emit     = !fakeShift;
          evtBreak = 1'b1;
          evtCode  = {1'b1, bus.scanByte};
        end
        ST_PAUSE: begin
          emit    = (pauseCnt == 3'd6);
          evtCode = PAUSE_CODE;
        end
        default: ;
      endcase
    end
    // The snapshot stored with an event is the modifier state after that event.
    evtMods = modQ;
    if (emit) evtMods = evtBreak ? (modQ & ~modMask(evtCode)) : (modQ | modMask(evtCode));
    statSet[STAT_OVF] = emit && fifoFull && !pop;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idleCnt  <= '0;
      pauseCnt <= '0;
      modQ     <= '0;
      statQ    <= '0;
    end else begin
      if (bus.scanValid || nextState == ST_IDLE) idleCnt <= '0;
      else                                       idleCnt <= idleCnt + TW'(1);
      if (state == ST_PAUSE && nextState == ST_PAUSE) pauseCnt <= pauseCnt + {2'b00, bus.scanValid};
      else                                            pauseCnt <= '0;
      modQ  <= evtMods;
      statQ <= (bus.statClr ? 8'h00 : statQ) | statSet;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (emit),
    .pushData ({evtCode, evtBreak, evtMods}),
    .pop      (pop),
    .head     (head),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (dbgCount)
  );

  assign bus.keyValid = !fifoEmpty;
  assign bus.keyCode  = head[17:9];
  assign bus.keyBreak = head[8];
  assign bus.keyMods  = head[7:0];
  assign bus.modState = modQ;
  assign bus.kbStat   = statQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_ps2_scan_decode.sv
// Directed bench for ps2_scan_decode: prefixes, modifiers, Pause, FIFO limits, timeout, status.
module tb_ps2_scan_decode;
  import ps2_scan_decode_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 200;

  logic       clock;
  logic       reset;
  scanState_t dbgState;
  logic [2:0] dbgCount;
  int         errors;
  int         checks;
  logic [18:0] obsHead;
  logic [18:0] expHead;

  ps2_scan_decode_if bus ();

  ps2_scan_decode #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .dbgState (dbgState),
    .dbgCount (dbgCount)
  );

  assign obsHead = {bus.keyValid, bus.keyCode, bus.keyBreak, bus.keyMods};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // All driver tasks start and end on a falling edge.
  task automatic sendByte(input logic [7:0] b);
    bus.scanValid = 1'b1;
    bus.scanByte  = b;
    @(negedge clock);
    bus.scanValid = 1'b0;
  endtask

  task automatic popOne;
    bus.keyReady = 1'b1;
    @(negedge clock);
    bus.keyReady = 1'b0;
  endtask

  task automatic clearStat;
    bus.statClr = 1'b1;
    @(negedge clock);
    bus.statClr = 1'b0;
  endtask

  task automatic test_reset;
    bus.scanValid = 1'b1;
    bus.scanByte  = 8'h1C;
    repeat (2) @(negedge clock);
    checks++; if (obsHead !== 19'h0) begin errors++; $display("FAIL reset_head: got %h want 00000", obsHead); end
    checks++; if (bus.modState !== 8'h00) begin errors++; $display("FAIL reset_mods: got %h want 00", bus.modState); end
    checks++; if (bus.kbStat !== 8'h00) begin errors++; $display("FAIL reset_stat: got %h want 00", bus.kbStat); end
    checks++; if (dbgState !== ST_IDLE || dbgCount !== 3'd0) begin errors++; $display("FAIL reset_fsm: got state=%0d count=%0d want 0/0", dbgState, dbgCount); end
    bus.scanValid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("FAIL reset_ignore: got keyValid=%b want 0", bus.keyValid); end
  endtask

  task automatic test_make;
    sendByte(8'h1C);
    expHead = {1'b1, 9'h01C, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead) begin errors++; $display("FAIL make_1c: got %h want %h", obsHead, expHead); end
    popOne();
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("FAIL make_pop: got keyValid=%b want 0", bus.keyValid); end
  endtask

  task automatic test_ext_break;
    sendByte(8'hE0);
    checks++; if (dbgState !== ST_EXT || bus.keyValid !== 1'b0) begin errors++; $display("FAIL ext_state: got state=%0d valid=%b want 2/0", dbgState, bus.keyValid); end
    sendByte(8'hF0);
    checks++; if (dbgState !== ST_EXTBRK) begin errors++; $display("FAIL extbrk_state: got %0d want 3", dbgState); end
    sendByte(8'h75);
    expHead = {1'b1, 9'h175, 1'b1, 8'h00};
    checks++; if (obsHead !== expHead) begin errors++; $display("FAIL ext_break_175: got %h want %h", obsHead, expHead); end
    checks++; if (dbgState !== ST_IDLE) begin errors++; $display("FAIL ext_break_idle: got %0d want 0", dbgState); end
    popOne();
  endtask

  task automatic test_modifiers;
    logic [18:0] exp_q[$];
    sendByte(8'h12);
    checks++; if (bus.modState !== 8'h01) begin errors++; $display("FAIL mod_lshift_set: got %h want 01", bus.modState); end
    sendByte(8'h1C);
    sendByte(8'hF0);
    sendByte(8'h12);
    checks++; if (bus.modState !== 8'h00 || dbgCount !== 3'd3) begin errors++; $display("FAIL mod_lshift_clr: got mods=%h count=%0d want 00/3", bus.modState, dbgCount); end
    exp_q.push_back({1'b1, 9'h012, 1'b0, 8'h01});
    exp_q.push_back({1'b1, 9'h01C, 1'b0, 8'h01});
    exp_q.push_back({1'b1, 9'h012, 1'b1, 8'h00});
    while (exp_q.size() > 0) begin
      expHead = exp_q.pop_front();
      checks++; if (obsHead !== expHead) begin errors++; $display("FAIL mod_event: got %h want %h", obsHead, expHead); end
      popOne();
    end
    sendByte(8'hE0);
    sendByte(8'h14);
    expHead = {1'b1, 9'h114, 1'b0, 8'h08};
    checks++; if (obsHead !== expHead || bus.modState !== 8'h08) begin errors++; $display("FAIL mod_rctrl_make: got %h mods=%h want %h mods=08", obsHead, bus.modState, expHead); end
    popOne();
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h14);
    expHead = {1'b1, 9'h114, 1'b1, 8'h00};
    checks++; if (obsHead !== expHead || bus.modState !== 8'h00) begin errors++; $display("FAIL mod_rctrl_break: got %h mods=%h want %h mods=00", obsHead, bus.modState, expHead); end
    popOne();
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) sendByte(seq[i]);
    checks++; if (bus.keyValid !== 1'b0 || dbgState !== ST_PAUSE) begin errors++; $display("FAIL pause_swallow: got valid=%b state=%0d want 0/4", bus.keyValid, dbgState); end
    sendByte(seq[7]);
    expHead = {1'b1, 9'h1E1, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead || dbgCount !== 3'd1) begin errors++; $display("FAIL pause_event: got %h count=%0d want %h count=1", obsHead, dbgCount, expHead); end
    checks++; if (bus.modState !== 8'h00 || dbgState !== ST_IDLE) begin errors++; $display("FAIL pause_mods: got mods=%h state=%0d want 00/0", bus.modState, dbgState); end
    popOne();
    sendByte(8'hE0); sendByte(8'h12);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h12);
    checks++; if (bus.keyValid !== 1'b0 || bus.modState !== 8'h00 || dbgState !== ST_IDLE) begin errors++; $display("FAIL fake_shift: got valid=%b mods=%h state=%0d want 0/00/0", bus.keyValid, bus.modState, dbgState); end
  endtask

  task automatic test_overflow;
    clearStat();
    for (int i = 0; i < 4; i++) sendByte(8'h1C + 8'(i));
    checks++; if (dbgCount !== 3'd4 || bus.kbStat !== 8'h00) begin errors++; $display("FAIL fifo_full: got count=%0d stat=%h want 4/00", dbgCount, bus.kbStat); end
    sendByte(8'h20);
    checks++; if (dbgCount !== 3'd4 || bus.kbStat !== 8'h20) begin errors++; $display("FAIL fifo_overflow: got count=%0d stat=%h want 4/20", dbgCount, bus.kbStat); end
    for (int i = 0; i < 4; i++) begin
      expHead = {1'b1, 1'b0, 8'h1C + 8'(i), 1'b0, 8'h00};
      checks++; if (obsHead !== expHead) begin errors++; $display("FAIL fifo_drain_%0d: got %h want %h", i, obsHead, expHead); end
      popOne();
    end
    checks++; if (bus.keyValid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got keyValid=%b want 0", bus.keyValid); end
  endtask

  task automatic test_back_to_back;
    clearStat();
    for (int i = 0; i < 4; i++) sendByte(8'h21 + 8'(i));
    bus.scanValid = 1'b1; bus.scanByte = 8'h25; bus.keyReady = 1'b1;
    @(negedge clock);
    bus.scanValid = 1'b0; bus.keyReady = 1'b0;
    checks++; if (dbgCount !== 3'd4 || bus.kbStat !== 8'h00) begin errors++; $display("FAIL full_pushpop: got count=%0d stat=%h want 4/00", dbgCount, bus.kbStat); end
    for (int i = 0; i < 4; i++) begin
      expHead = {1'b1, 1'b0, 8'h22 + 8'(i), 1'b0, 8'h00};
      checks++; if (obsHead !== expHead) begin errors++; $display("FAIL full_pushpop_drain_%0d: got %h want %h", i, obsHead, expHead); end
      popOne();
    end
    sendByte(8'h26);
    bus.scanValid = 1'b1; bus.scanByte = 8'h27; bus.keyReady = 1'b1;
    @(negedge clock);
    bus.scanValid = 1'b0; bus.keyReady = 1'b0;
    expHead = {1'b1, 9'h027, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead || dbgCount !== 3'd1) begin errors++; $display("FAIL one_pushpop: got %h count=%0d want %h count=1", obsHead, dbgCount, expHead); end
    popOne();
  endtask

  task automatic test_timeout;
    clearStat();
    sendByte(8'hE0);
    repeat (TIMEOUT - 1) @(negedge clock);
    checks++; if (dbgState !== ST_EXT || bus.kbStat !== 8'h00) begin errors++; $display("FAIL timeout_early: got state=%0d stat=%h want 2/00", dbgState, bus.kbStat); end
    sendByte(8'h75);
    expHead = {1'b1, 9'h175, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead) begin errors++; $display("FAIL timeout_edge_event: got %h want %h", obsHead, expHead); end
    popOne();
    sendByte(8'hE0);
    repeat (TIMEOUT) @(negedge clock);
    checks++; if (dbgState !== ST_IDLE || bus.kbStat !== 8'h40) begin errors++; $display("FAIL timeout_abort: got state=%0d stat=%h want 0/40", dbgState, bus.kbStat); end
    sendByte(8'h1C);
    expHead = {1'b1, 9'h01C, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead) begin errors++; $display("FAIL timeout_after: got %h want %h", obsHead, expHead); end
    popOne();
  endtask

  task automatic test_status;
    clearStat();
    sendByte(8'hAA);
    checks++; if (bus.kbStat !== 8'h01 || bus.keyValid !== 1'b0) begin errors++; $display("FAIL stat_bat: got stat=%h valid=%b want 01/0", bus.kbStat, bus.keyValid); end
    clearStat();
    checks++; if (bus.kbStat !== 8'h00) begin errors++; $display("FAIL stat_clr: got %h want 00", bus.kbStat); end
    sendByte(8'hFE); sendByte(8'hEE); sendByte(8'h00); sendByte(8'hFF);
    checks++; if (bus.kbStat !== 8'h1C || bus.keyValid !== 1'b0) begin errors++; $display("FAIL stat_codes: got stat=%h valid=%b want 1C/0", bus.kbStat, bus.keyValid); end
    bus.statClr = 1'b1;
    sendByte(8'hFA);
    bus.statClr = 1'b0;
    checks++; if (bus.kbStat !== 8'h02) begin errors++; $display("FAIL stat_clr_vs_set: got %h want 02", bus.kbStat); end
  endtask

  task automatic test_reset_mid;
    sendByte(8'hE0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sendByte(8'h75);
    expHead = {1'b1, 9'h075, 1'b0, 8'h00};
    checks++; if (obsHead !== expHead || bus.kbStat !== 8'h00) begin errors++; $display("FAIL reset_mid: got %h stat=%h want %h stat=00", obsHead, bus.kbStat, expHead); end
    popOne();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.scanValid = 1'b0;
    bus.scanByte  = 8'h00;
    bus.keyReady  = 1'b0;
    bus.statClr   = 1'b0;
    @(negedge clock);
    test_reset();
    test_make();
    test_ext_break();
    test_modifiers();
    test_pause();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_status();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
